// File: rtl/inst_mem.sv
// -----------------------------------------------------------------------------
// inst_mem -- 8192 x 16-bit instruction memory with a byte-serial loader.
//
// Fetch side: mem_instr is registered and returns mem[mem_inst_addr] one cycle
// after the address is presented. Reads happen every cycle, including while a
// load session is in progress.
//
// Load side: a load_start pulse opens a session at word 0. Bytes arrive over a
// valid/ready handshake, low byte first, then high byte. Each byte pair forms
// one 16-bit word. After LOAD_WORDS words the session closes and load_done
// pulses for one cycle. A load_start during a session restarts it at word 0.
// Words already written stay in the array.
//
// Parameters
//   LOAD_WORDS       words written per load session (1..8192)
//
// Ports
//   clk              sole clock, rising edge
//   rst_async        asynchronous active-high reset. It does not clear the
//                    array.
//   mem_inst_addr    fetch word address
//   mem_instr        registered fetch data. The even-PC byte is in [7:0] and
//                    the odd-PC byte is in [15:8].
//   load_start       single-cycle pulse that starts or restarts a session
//   load_byte        loader data byte
//   load_byte_valid  load_byte is valid this cycle
//   load_byte_ready  a byte is accepted this cycle if valid is also high
//   load_active      a session is in progress
//   load_done        one-cycle pulse after the final word is written
//   load_word_count  words written in the current or most recent session
//
// Build option
//   INST_MEM_WRITE_BYPASS_EN
//     When defined, a fetch read and a loader write to the same address in the
//     same cycle return the newly written word.
//     When not defined, that case is read-first and returns the old contents.
// -----------------------------------------------------------------------------
module inst_mem #(
   parameter int LOAD_WORDS = 8192
) (
   input  logic        clk,
   input  logic        rst_async,
   input  logic [12:0] mem_inst_addr,
   output logic [15:0] mem_instr,
   input  logic        load_start,
   input  logic [7:0]  load_byte,
   input  logic        load_byte_valid,
   output logic        load_byte_ready,
   output logic        load_active,
   output logic        load_done,
   output logic [13:0] load_word_count
);

   localparam int          MEM_DEPTH = 8192;
   localparam logic [12:0] LAST_ADDR = 13'(LOAD_WORDS - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOW_BYTE  = 2'd1,
      HIGH_BYTE = 2'd2
   } load_state_t;

   load_state_t state_reg;
   logic [12:0] load_addr_reg;
   logic [13:0] word_count_reg;
   logic [7:0]  low_byte_reg;
   logic        load_done_reg;
   logic [15:0] mem_instr_reg;

   // The array has no reset, so loaded code survives a reset.
   logic [15:0] mem [0:MEM_DEPTH-1];

   logic        byte_accept;
   logic        wr_en;
   logic [15:0] wr_data;
   logic        last_word;

   // A start pulse takes priority over the handshake.
   // No byte is consumed in a restart cycle.
   assign load_byte_ready = (state_reg != IDLE) && !load_start;
   assign byte_accept     = load_byte_ready && load_byte_valid;
   assign wr_en           = byte_accept && (state_reg == HIGH_BYTE);
   assign wr_data         = {load_byte, low_byte_reg};
   assign last_word       = (load_addr_reg == LAST_ADDR);

   // ---------------------------------------------------------------------------
   // Loader FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         state_reg      <= IDLE;
         load_addr_reg  <= '0;
         word_count_reg <= '0;
         low_byte_reg   <= '0;
         load_done_reg  <= 1'b0;
      end else begin
         load_done_reg <= 1'b0;
         if (load_start) begin
            // Start or restart. Any half-assembled word is thrown away.
            state_reg      <= LOW_BYTE;
            load_addr_reg  <= '0;
            word_count_reg <= '0;
            low_byte_reg   <= '0;
         end else begin
            case (state_reg)
               LOW_BYTE: begin
                  if (byte_accept) begin
                     low_byte_reg <= load_byte;
                     state_reg    <= HIGH_BYTE;
                  end
               end
               HIGH_BYTE: begin
                  if (byte_accept) begin
                     word_count_reg <= word_count_reg + 14'd1;
                     if (last_word) begin
                        // The address stays at the last word.
                        // It never runs past the end of the session.
                        state_reg     <= IDLE;
                        load_done_reg <= 1'b1;
                     end else begin
                        load_addr_reg <= load_addr_reg + 13'd1;
                        state_reg     <= LOW_BYTE;
                     end
                  end
               end
               default: begin
                  // IDLE: wait for load_start. Valid bytes are ignored here.
               end
            endcase
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Storage write port
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[load_addr_reg] <= wr_data;
      end
   end

   // ---------------------------------------------------------------------------
   // Registered fetch read
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         mem_instr_reg <= '0;
      end else begin
`ifdef INST_MEM_WRITE_BYPASS_EN
         // Forward the word being written so a fetch never sees stale data.
         if (wr_en && (load_addr_reg == mem_inst_addr)) begin
            mem_instr_reg <= wr_data;
         end else begin
            mem_instr_reg <= mem[mem_inst_addr];
         end
`else
         // Read-first: a same-address write becomes visible one read later.
         mem_instr_reg <= mem[mem_inst_addr];
`endif
      end
   end

   assign mem_instr       = mem_instr_reg;
   assign load_active     = (state_reg != IDLE);
   assign load_done       = load_done_reg;
   assign load_word_count = word_count_reg;

endmodule

// File: tb/tb_inst_mem.sv
// -----------------------------------------------------------------------------
// tb_inst_mem -- self-checking bench for inst_mem, built with LOAD_WORDS = 4.
//
// The reference model treats a load session as a stream of accepted bytes:
//   - Bytes collect in a queue.
//   - Every two bytes form the next word, low byte first.
//   - The word index equals the number of words already written.
// Directed scenarios run first. Randomized traffic follows, with occasional
// restarts and resets.
// -----------------------------------------------------------------------------
module tb_inst_mem;

   localparam int LW = 4;

   logic        clk;
   logic        rst_async;
   logic [12:0] mem_inst_addr;
   logic [15:0] mem_instr;
   logic        load_start;
   logic [7:0]  load_byte;
   logic        load_byte_valid;
   logic        load_byte_ready;
   logic        load_active;
   logic        load_done;
   logic [13:0] load_word_count;

   inst_mem #(.LOAD_WORDS(LW)) dut (
      .clk             (clk),
      .rst_async       (rst_async),
      .mem_inst_addr   (mem_inst_addr),
      .mem_instr       (mem_instr),
      .load_start      (load_start),
      .load_byte       (load_byte),
      .load_byte_valid (load_byte_valid),
      .load_byte_ready (load_byte_ready),
      .load_active     (load_active),
      .load_done       (load_done),
      .load_word_count (load_word_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [15:0] m_mem   [0:8191];
   bit          m_known [0:8191];
   bit          m_active;
   logic [7:0]  m_q [$];
   int          m_cnt;
   bit          m_done;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle of stimulus.
   // The model predicts the ready response and the post-edge outputs.
   task automatic cycle(input bit st, input bit v, input logic [7:0] b, input logic [12:0] a);
      bit          wr;
      bit          rd_known;
      logic [12:0] wa;
      logic [15:0] wd;
      logic [15:0] exp_rd;
      wr = 1'b0;
      wa = '0;
      wd = '0;
      @(negedge clk);
      load_start      = st;
      load_byte_valid = v;
      load_byte       = b;
      mem_inst_addr   = a;
      #1;
      check("ready", {15'd0, load_byte_ready}, {15'd0, (m_active && !st)});
      m_done = 1'b0;
      if (st) begin
         m_active = 1'b1;
         m_q.delete();
         m_cnt = 0;
      end else if (m_active && v) begin
         m_q.push_back(b);
         if (m_q.size() == 2) begin
            wr = 1'b1;
            wa = 13'(m_cnt);
            wd = {m_q[1], m_q[0]};
            m_q.delete();
            m_cnt++;
            if (m_cnt == LW) begin
               m_active = 1'b0;
               m_done   = 1'b1;
            end
         end
      end
      rd_known = m_known[a];
      exp_rd   = m_mem[a];
`ifdef INST_MEM_WRITE_BYPASS_EN
      if (wr && wa == a) begin
         rd_known = 1'b1;
         exp_rd   = wd;
      end
`endif
      if (wr) begin
         m_mem[wa]   = wd;
         m_known[wa] = 1'b1;
         $display("write mem[%0d] = %h (count %0d)", wa, wd, m_cnt);
      end
      @(posedge clk);
      #1;
      check("active", {15'd0, load_active}, {15'd0, m_active});
      check("count", {2'd0, load_word_count}, 16'(m_cnt));
      check("done", {15'd0, load_done}, {15'd0, m_done});
      if (rd_known) check("instr", mem_instr, exp_rd);
   endtask

   // Asserts reset between clock edges and checks that the outputs clear at once.
   task automatic do_reset(input logic [12:0] a);
      @(negedge clk);
      load_start      = 1'b0;
      load_byte_valid = 1'b0;
      mem_inst_addr   = a;
      #2;
      rst_async = 1'b1;
      #1;
      check("rst_active", {15'd0, load_active}, 16'd0);
      check("rst_count", {2'd0, load_word_count}, 16'd0);
      check("rst_done", {15'd0, load_done}, 16'd0);
      check("rst_instr", mem_instr, 16'h0000);
      m_active = 1'b0;
      m_done   = 1'b0;
      m_cnt    = 0;
      m_q.delete();
      @(posedge clk);
      #1;
      check("rst_instr_hold", mem_instr, 16'h0000);
      @(negedge clk);
      rst_async = 1'b0;
      $display("reset applied (addr %0d)", a);
   endtask

   // Presents an address for one idle cycle and checks the fetched word
   // against a fixed expected value.
   task automatic read_const(input string tag, input logic [12:0] a, input logic [15:0] exp);
      cycle(1'b0, 1'b0, 8'h00, a);
      check(tag, mem_instr, exp);
   endtask

   // Sends one byte with valid held high.
   task automatic send(input logic [7:0] b, input logic [12:0] a);
      cycle(1'b0, 1'b1, b, a);
   endtask

   logic [7:0] bytes_a [0:7];

   initial begin
      int r;
      rst_async       = 1'b0;
      load_start      = 1'b0;
      load_byte       = '0;
      load_byte_valid = 1'b0;
      mem_inst_addr   = '0;
      m_active        = 1'b0;
      m_cnt           = 0;
      m_done          = 1'b0;
      for (int i = 0; i < 8192; i++) begin
         m_known[i] = 1'b0;
         m_mem[i]   = '0;
      end

      do_reset(13'd0);

      // Put BEEF at word 0.
      // The following reset must not disturb it.
      cycle(1'b1, 1'b0, 8'h00, 13'd0);
      send(8'hEF, 13'd0); send(8'hBE, 13'd0);
      for (int i = 0; i < 6; i++) send(8'h00, 13'd0);
      do_reset(13'd0);
      read_const("rst_keeps_mem", 13'd0, 16'hBEEF);

      // Full session, valid always high.
      bytes_a[0] = 8'h11; bytes_a[1] = 8'h22; bytes_a[2] = 8'h33; bytes_a[3] = 8'h44;
      bytes_a[4] = 8'h55; bytes_a[5] = 8'h66; bytes_a[6] = 8'h77; bytes_a[7] = 8'h88;
      cycle(1'b1, 1'b0, 8'h00, 13'd1);
      for (int i = 0; i < 8; i++) send(bytes_a[i], 13'(i % 4));
      check("done_pulse", {15'd0, load_done}, 16'd1);
      cycle(1'b0, 1'b1, 8'h99, 13'd0);
      check("done_single", {15'd0, load_done}, 16'd0);
      check("count_final", {2'd0, load_word_count}, 16'd4);
      check("active_low", {15'd0, load_active}, 16'd0);
      read_const("w0", 13'd0, 16'h2211);
      read_const("w1", 13'd1, 16'h4433);
      read_const("w2", 13'd2, 16'h6655);
      read_const("w3", 13'd3, 16'h8877);

      // Valid toggled every other cycle.
      cycle(1'b1, 1'b0, 8'h00, 13'd0);
      for (int i = 0; i < 8; i++) begin
         cycle(1'b0, 1'b0, 8'hEE, 13'd2);
         send(8'(8'h91 + i), 13'd2);
      end
      read_const("t0", 13'd0, 16'h9291);
      read_const("t1", 13'd1, 16'h9493);
      read_const("t2", 13'd2, 16'h9695);
      read_const("t3", 13'd3, 16'h9897);

      // Write and fetch the same address in one cycle.
      cycle(1'b1, 1'b0, 8'h00, 13'd0);
      for (int i = 0; i < 8; i++) send(8'hFF, 13'd0);
      cycle(1'b1, 1'b0, 8'h00, 13'd0);
      send(8'h51, 13'd0); send(8'h51, 13'd0);
      send(8'h52, 13'd0); send(8'h52, 13'd0);
      send(8'h53, 13'd0); send(8'h53, 13'd0);
      send(8'h34, 13'd3);
      send(8'h12, 13'd3);
`ifdef INST_MEM_WRITE_BYPASS_EN
      check("same_addr_bypass", mem_instr, 16'h1234);
`else
      check("same_addr_readfirst", mem_instr, 16'hFFFF);
`endif
      read_const("same_addr_next", 13'd3, 16'h1234);

      // Restart in mid-session.
      cycle(1'b1, 1'b0, 8'h00, 13'd0);
      send(8'hAA, 13'd0); send(8'hBB, 13'd0); send(8'hCC, 13'd0);
      cycle(1'b1, 1'b1, 8'hDD, 13'd0);
      send(8'h01, 13'd0); send(8'h02, 13'd0);
      check("restart_count", {2'd0, load_word_count}, 16'd1);
      read_const("restart_w0", 13'd0, 16'h0201);
      read_const("restart_w1", 13'd1, 16'h5252);

      // Reset while in HIGH_BYTE after three words.
      cycle(1'b1, 1'b0, 8'h00, 13'd0);
      for (int i = 0; i < 7; i++) send(8'(8'h61 + i), 13'd0);
      check("pre_rst_count", {2'd0, load_word_count}, 16'd3);
      do_reset(13'd3);
      read_const("kept_w0", 13'd0, 16'h6261);
      read_const("kept_w1", 13'd1, 16'h6463);
      read_const("kept_w2", 13'd2, 16'h6665);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         r = int'($urandom_range(0, 199));
         if (r == 0) begin
            do_reset(13'($urandom_range(0, 3)));
         end else begin
            cycle(bit'((r < 6) || (!m_active && r < 60)),
                  bit'($urandom_range(0, 99) < 70),
                  8'($urandom),
                  13'($urandom_range(0, 3)));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
